// File: rtl/cbfp_norm_pp.sv
// Block-floating-point normaliser: ping-pong block buffer, block exponent search, shifted replay.
// Optional CBFP_ROUND_EN: round-half-up with positive saturation, one extra output stage.
module cbfp_norm_pp #(
  parameter int LANES     = 16,
  parameter int DIN_W     = 23,
  parameter int DOUT_W    = 11,
  parameter int BLK_BEATS = 4,
  parameter int EXP_W     = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  input  logic [LANES-1:0][DIN_W-1:0]    din,
  output logic                           valid_out,
  output logic                           sof_out,
  output logic [LANES-1:0][DOUT_W-1:0]   dout,
  output logic [EXP_W-1:0]               exp_out
);

  localparam int CNT_W = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLK_BEATS - 1);

  // Redundant sign bits: leading bits equal to the MSB, not counting the MSB itself.
  function automatic logic [EXP_W-1:0] rsb(input logic [DIN_W-1:0] x);
    logic [EXP_W-1:0] n;
    logic             run;
    n   = '0;
    run = 1'b1;
    for (int unsigned i = DIN_W - 1; i > 0; i--) begin
      if (run && (x[i-1] == x[DIN_W-1])) n = n + 1'b1;
      else                               run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [DOUT_W-1:0] shl_top(input logic [DIN_W-1:0] x,
                                                input logic [EXP_W-1:0] e);
    logic [DIN_W-1:0] s;
    s = x << e;
    return s[DIN_W-1 -: DOUT_W];
  endfunction

  logic [LANES-1:0][DIN_W-1:0] mem_q [2][BLK_BEATS];

  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic             draining_q, draining_d;
  logic [EXP_W-1:0] acc_q, acc_d, blk_exp_q, blk_exp_d;
  logic [EXP_W-1:0] beat_min, blk_min;
  logic             arm;

  logic                          valid_out_q, valid_out_d, sof_out_q, sof_out_d;
  logic [LANES-1:0][DOUT_W-1:0]  dout_q, dout_d;
  logic [EXP_W-1:0]              exp_out_q, exp_out_d;

  logic                          out_valid, out_sof;
  logic [EXP_W-1:0]              out_exp;
  logic [LANES-1:0][DOUT_W-1:0]  out_dout;
  logic [LANES-1:0][DIN_W-1:0]   rd_beat;

  always_ff @(posedge clk) begin
    if (valid_in) mem_q[wr_bank_q][wr_cnt_q] <= din;
  end

  assign rd_beat = mem_q[rd_bank_q][rd_cnt_q];

  always_comb begin
    beat_min = EXP_W'(DIN_W - 1);
    for (int unsigned l = 0; l < LANES; l++) begin
      if (rsb(din[l]) < beat_min) beat_min = rsb(din[l]);
    end
  end

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    acc_d     = acc_q;
    blk_exp_d = blk_exp_q;
    arm       = 1'b0;
    blk_min   = (wr_cnt_q == '0) ? beat_min : ((beat_min < acc_q) ? beat_min : acc_q);
    if (valid_in) begin
      acc_d = blk_min;
      if (wr_cnt_q == LAST_BEAT) begin
        arm       = 1'b1;
        wr_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
        blk_exp_d = blk_min;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  // Arming wins over drain completion: a back-to-back block re-arms on the old block's last beat.
  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    rd_bank_d  = rd_bank_q;
    draining_d = draining_q;
    if (draining_q) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == LAST_BEAT) draining_d = 1'b0;
    end
    if (arm) begin
      draining_d = 1'b1;
      rd_cnt_d   = '0;
      rd_bank_d  = wr_bank_q;
    end
  end

`ifdef CBFP_ROUND_EN
  localparam logic [DOUT_W-1:0] MAX_POS = {1'b0, {(DOUT_W-1){1'b1}}};

  function automatic logic shl_rbit(input logic [DIN_W-1:0] x, input logic [EXP_W-1:0] e);
    logic [DIN_W-1:0] s;
    s = x << e;
    return s[DIN_W-DOUT_W-1];
  endfunction

  logic                          p_valid_q, p_valid_d, p_sof_q, p_sof_d;
  logic [EXP_W-1:0]              p_exp_q, p_exp_d;
  logic [LANES-1:0][DOUT_W-1:0]  p_top_q, p_top_d;
  logic [LANES-1:0]              p_rbit_q, p_rbit_d;

  always_comb begin
    p_valid_d = draining_q;
    p_sof_d   = draining_q && (rd_cnt_q == '0);
    p_exp_d   = p_exp_q;
    p_top_d   = p_top_q;
    p_rbit_d  = p_rbit_q;
    if (draining_q) begin
      p_exp_d = blk_exp_q;
      for (int unsigned l = 0; l < LANES; l++) begin
        p_top_d[l]  = shl_top(rd_beat[l], blk_exp_q);
        p_rbit_d[l] = shl_rbit(rd_beat[l], blk_exp_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_q <= 1'b0;
      p_sof_q   <= 1'b0;
      p_exp_q   <= '0;
      p_top_q   <= '0;
      p_rbit_q  <= '0;
    end else begin
      p_valid_q <= p_valid_d;
      p_sof_q   <= p_sof_d;
      p_exp_q   <= p_exp_d;
      p_top_q   <= p_top_d;
      p_rbit_q  <= p_rbit_d;
    end
  end

  always_comb begin
    out_valid = p_valid_q;
    out_sof   = p_sof_q;
    out_exp   = p_exp_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (p_rbit_q[l] && (p_top_q[l] == MAX_POS)) out_dout[l] = MAX_POS;
      else out_dout[l] = p_top_q[l] + DOUT_W'(p_rbit_q[l]);
    end
  end
`else
  always_comb begin
    out_valid = draining_q;
    out_sof   = draining_q && (rd_cnt_q == '0);
    out_exp   = blk_exp_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      out_dout[l] = shl_top(rd_beat[l], blk_exp_q);
    end
  end
`endif

  always_comb begin
    valid_out_d = out_valid;
    sof_out_d   = out_valid && out_sof;
    exp_out_d   = out_valid ? out_exp : exp_out_q;
    dout_d      = out_valid ? out_dout : dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      acc_q       <= '0;
      blk_exp_q   <= '0;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      draining_q  <= 1'b0;
      valid_out_q <= 1'b0;
      sof_out_q   <= 1'b0;
      dout_q      <= '0;
      exp_out_q   <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      acc_q       <= acc_d;
      blk_exp_q   <= blk_exp_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      draining_q  <= draining_d;
      valid_out_q <= valid_out_d;
      sof_out_q   <= sof_out_d;
      dout_q      <= dout_d;
      exp_out_q   <= exp_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign sof_out   = sof_out_q;
  assign dout      = dout_q;
  assign exp_out   = exp_out_q;

endmodule

// File: tb/tb_cbfp_norm_pp.sv
// Scoreboard bench for cbfp_norm_pp (truncation build): directed blocks, hand-derived exponents.
module tb_cbfp_norm_pp;
  localparam int LANES     = 16;
  localparam int DIN_W     = 23;
  localparam int DOUT_W    = 11;
  localparam int BLK_BEATS = 4;
  localparam int EXP_W     = 5;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          valid_in = 1'b0;
  logic [LANES-1:0][DIN_W-1:0]   din = '0;
  logic                          valid_out, sof_out;
  logic [LANES-1:0][DOUT_W-1:0]  dout;
  logic [EXP_W-1:0]              exp_out;

  cbfp_norm_pp #(.LANES(LANES), .DIN_W(DIN_W), .DOUT_W(DOUT_W),
                 .BLK_BEATS(BLK_BEATS), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din(din),
    .valid_out(valid_out), .sof_out(sof_out), .dout(dout), .exp_out(exp_out));

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0][DOUT_W-1:0] d;
    logic [EXP_W-1:0]             e;
    logic                         sof;
    int                           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   blk [BLK_BEATS][LANES];

  always @(posedge clk) cyc++;

  // Output of x scaled by 2**e, keeping the top DOUT_W bits of a DIN_W word (floor).
  function automatic logic [DOUT_W-1:0] expd(input int x, input int e);
    longint s;
    s = longint'(x) <<< e;
    s = s >>> (DIN_W - DOUT_W);
    return s[DOUT_W-1:0];
  endfunction

  task automatic fill(input int kind);
    int p1 [4];
    int p5 [4];
    p1 = '{300, -300, 1, 0};
    p5 = '{200, -150, 7, -256};
    for (int b = 0; b < BLK_BEATS; b++)
      for (int l = 0; l < LANES; l++)
        case (kind)
          1: blk[b][l] = p1[(l + b) % 4];
          2: blk[b][l] = 0;
          3: blk[b][l] = -1;
          4: blk[b][l] = (b == 0 && l == 0) ? 4194303 : 0;
          5: blk[b][l] = (p5[(l + b) % 4] == -256) ? -256 : p5[(l + b) % 4] + (l % 3);
          default: blk[b][l] = (b == 2 && l == 5) ? -4194304 : 4096 * l;
        endcase
  endtask

  task automatic send_block(input int e, input logic [2*BLK_BEATS-1:0] gaps, input int nbeats);
    int   last;
    exp_t it;
    last = 0;
    for (int b = 0; b < nbeats; b++) begin
      for (int g = 0; g < int'(gaps[2*b +: 2]); g++) begin
        @(negedge clk);
        valid_in = 1'b0;
      end
      @(negedge clk);
      valid_in = 1'b1;
      for (int l = 0; l < LANES; l++) din[l] = DIN_W'(blk[b][l]);
      last = cyc + 1;
    end
    if (nbeats == BLK_BEATS) begin
      for (int b = 0; b < BLK_BEATS; b++) begin
        for (int l = 0; l < LANES; l++) it.d[l] = expd(blk[b][l], e);
        it.e   = EXP_W'(e);
        it.sof = (b == 0);
        it.cyc = last + 1 + b;
        q.push_back(it);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (valid_out !== 1'b0 || sof_out !== 1'b0 || dout !== '0 || exp_out !== '0) begin
      errors++;
      $display("FAIL %s: valid=%b sof=%b exp=%0d dout=%h, want all zero",
               tag, valid_out, sof_out, exp_out, dout);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_out) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: cyc=%0d valid_out=1, want 0", cyc);
        end else begin
          exp_t f;
          f = q.pop_front();
          if (f.cyc != cyc || dout !== f.d || exp_out !== f.e || sof_out !== f.sof) begin
            errors++;
            $display("FAIL beat: cyc=%0d exp=%0d sof=%b dout=%h, want cyc=%0d exp=%0d sof=%b dout=%h",
                     cyc, exp_out, sof_out, dout, f.cyc, f.e, f.sof, f.d);
          end
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_beat: cyc=%0d valid_out=0, want beat due at cyc=%0d", cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int n;
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    fill(1); send_block(13, '0, BLK_BEATS); idle(); wait_drain();
    fill(2); send_block(22, '0, BLK_BEATS); idle();
    fill(3); send_block(22, '0, BLK_BEATS); idle();
    fill(4); send_block(0,  '0, BLK_BEATS); idle();
    fill(6); send_block(0,  '0, BLK_BEATS); idle(); wait_drain();

    fill(1); send_block(13, '0, BLK_BEATS);
    fill(2); send_block(22, '0, BLK_BEATS);
    fill(5); send_block(14, '0, BLK_BEATS); idle(); wait_drain();

    fill(1); send_block(13, {2'd1, 2'd3, 2'd0, 2'd2}, BLK_BEATS); idle(); wait_drain();
    fill(5); send_block(14, {2'd2, 2'd2, 2'd1, 2'd3}, BLK_BEATS); idle(); wait_drain();

    fill(4); send_block(0, '0, 2);
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_partial");
    @(negedge clk);
    rst = 1'b0;
    fill(1); send_block(13, '0, BLK_BEATS); idle(); wait_drain();

    fill(5); send_block(14, '0, BLK_BEATS); idle();
    n = 0;
    while (!valid_out && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!valid_out) begin
      errors++;
      $display("FAIL drain_start: valid_out=0 after %0d cycles, want 1", n);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_drain");
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: valid_out=%b, want 0", valid_out);
    end
    fill(6); send_block(0, {2'd0, 2'd1, 2'd0, 2'd0}, BLK_BEATS); idle(); wait_drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
